// File: rtl/ulpb_tx_arbiter_if.sv
// Requester-side and node-side TX signals of ulpb_tx_arbiter.
// master = arbiter view; slave = the requesters plus the node TX port.
interface ulpb_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) ();
    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]        REQ_PEND;
    logic [NUM_REQ-1:0]        REQ_ACK;
    logic [NUM_REQ-1:0]        REQ_SUCC;
    logic [NUM_REQ-1:0]        REQ_FAIL;
    logic [NUM_REQ-1:0]        REQ_RESP_ACK;
    logic [NUM_REQ-1:0]        GRANT;
    logic [ADDR_W-1:0]         TX_ADDR;
    logic [DATA_W-1:0]         TX_DATA;
    logic                      TX_REQ;
    logic                      TX_PEND;
    logic                      PRIORITY;
    logic                      TX_ACK;
    logic                      TX_SUCC;
    logic                      TX_FAIL;
    logic                      TX_RESP_ACK;

    modport master (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, REQ_PEND, REQ_RESP_ACK,
               TX_ACK, TX_SUCC, TX_FAIL,
        output REQ_ACK, REQ_SUCC, REQ_FAIL, GRANT,
               TX_ADDR, TX_DATA, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, REQ_DATA, REQ_PEND, REQ_RESP_ACK,
               TX_ACK, TX_SUCC, TX_FAIL,
        input  REQ_ACK, REQ_SUCC, REQ_FAIL, GRANT,
               TX_ADDR, TX_DATA, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK
    );
endinterface

// File: rtl/ulpb_tx_arbiter.sv
// Round-robin arbiter sharing one ulpb_node32 TX port among NUM_REQ requesters, grant locked per burst.
// Optional macro ULPB_ARB_FIXED_PRI_EN: requester 0 always wins arbitration and raises PRIORITY.
module ulpb_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic              CLK_EXT,
    input  logic              RESET,
    ulpb_tx_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WACK   = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;
    localparam logic [2:0] ST_RACK   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  tx_addr_q, tx_addr_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_pend_q, tx_pend_d;
    logic               tx_req_q, tx_req_d;
    logic               ack_q, ack_d;
    logic               succ_q, succ_d;
    logic               fail_q, fail_d;
    logic               resp_ack_q, resp_ack_d;
    logic               first_q, first_d;

    logic [ADDR_W-1:0]  req_addr_a [NUM_REQ];
    logic [DATA_W-1:0]  req_data_a [NUM_REQ];
    logic [PTR_W-1:0]   pick_idx;
    logic               node_result;
    logic               in_burst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_addr_a[gi] = bus.REQ_ADDR[gi*ADDR_W +: ADDR_W];
            assign req_data_a[gi] = bus.REQ_DATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Scan farthest-first so the valid requester closest to the pointer is the last one assigned.
    always_comb begin
        pick_idx = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.REQ_VALID[rr_idx(ptr_q, k)]) pick_idx = rr_idx(ptr_q, k);
        end
`ifdef ULPB_ARB_FIXED_PRI_EN
        if (bus.REQ_VALID[0]) pick_idx = '0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        tx_addr_d   = tx_addr_q;
        tx_data_d   = tx_data_q;
        tx_pend_d   = tx_pend_q;
        tx_req_d    = tx_req_q;
        ack_d       = ack_q;
        succ_d      = succ_q;
        fail_d      = fail_q;
        resp_ack_d  = resp_ack_q;
        first_d     = first_q;
        node_result = bus.TX_SUCC | bus.TX_FAIL;
        in_burst    = (state_q == ST_REQ) || (state_q == ST_WACK) ||
                      (state_q == ST_NEXT) || (state_q == ST_RESULT);

        // A node result during the burst ends it at once (normal completion or node-side abort).
        if (in_burst && node_result) begin
            tx_req_d = 1'b0;
            ack_d    = 1'b0;
            succ_d   = bus.TX_SUCC & ~bus.TX_FAIL;
            fail_d   = bus.TX_FAIL;
            state_d  = ST_RACK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.REQ_VALID) begin
                        gidx_d    = pick_idx;
                        grant_d   = NUM_REQ'(1) << pick_idx;
                        tx_addr_d = req_addr_a[pick_idx];
                        tx_data_d = req_data_a[pick_idx];
                        tx_pend_d = bus.REQ_PEND[pick_idx];
                        tx_req_d  = 1'b1;
                        first_d   = 1'b1;
                        state_d   = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.TX_ACK) begin
                        tx_req_d = 1'b0;
                        ack_d    = 1'b1;
                        state_d  = ST_WACK;
                    end
                end
                ST_WACK: begin
                    if (!bus.REQ_VALID[gidx_q] && !bus.TX_ACK) begin
                        ack_d   = 1'b0;
                        state_d = tx_pend_q ? ST_NEXT : ST_RESULT;
                    end
                end
                ST_NEXT: begin
                    if (bus.REQ_VALID[gidx_q]) begin
                        tx_addr_d = req_addr_a[gidx_q];
                        tx_data_d = req_data_a[gidx_q];
                        tx_pend_d = bus.REQ_PEND[gidx_q];
                        tx_req_d  = 1'b1;
                        first_d   = 1'b0;
                        state_d   = ST_REQ;
                    end
                end
                ST_RACK: begin
                    if (bus.REQ_RESP_ACK[gidx_q]) resp_ack_d = 1'b1;
                    // Release only after both sides have seen and dropped the response handshake.
                    if (resp_ack_q && !node_result && !bus.REQ_RESP_ACK[gidx_q]) begin
                        succ_d     = 1'b0;
                        fail_d     = 1'b0;
                        resp_ack_d = 1'b0;
                        grant_d    = '0;
                        ptr_d      = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_EXT) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            tx_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_pend_q  <= 1'b0;
            tx_req_q   <= 1'b0;
            ack_q      <= 1'b0;
            succ_q     <= 1'b0;
            fail_q     <= 1'b0;
            resp_ack_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            tx_addr_q  <= tx_addr_d;
            tx_data_q  <= tx_data_d;
            tx_pend_q  <= tx_pend_d;
            tx_req_q   <= tx_req_d;
            ack_q      <= ack_d;
            succ_q     <= succ_d;
            fail_q     <= fail_d;
            resp_ack_q <= resp_ack_d;
            first_q    <= first_d;
        end
    end

    assign bus.GRANT       = grant_q;
    assign bus.REQ_ACK     = grant_q & {NUM_REQ{ack_q}};
    assign bus.REQ_SUCC    = grant_q & {NUM_REQ{succ_q}};
    assign bus.REQ_FAIL    = grant_q & {NUM_REQ{fail_q}};
    assign bus.TX_ADDR     = tx_addr_q;
    assign bus.TX_DATA     = tx_data_q;
    assign bus.TX_REQ      = tx_req_q;
    assign bus.TX_PEND     = tx_pend_q;
    assign bus.TX_RESP_ACK = resp_ack_q;

`ifdef ULPB_ARB_FIXED_PRI_EN
    assign bus.PRIORITY = grant_q[0] & tx_req_q & first_q;
`else
    logic prio_unused;
    assign prio_unused  = first_q;
    assign bus.PRIORITY = 1'b0;
`endif
endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Directed bench for ulpb_tx_arbiter: single words, locked bursts, round-robin order,
// node abort, reset mid-transaction and the priority/pointer corner.
module tb_ulpb_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  addr_t [4];
    logic [31:0] data_t [4];
    logic        pend_t [4];

    ulpb_tx_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32)) bus ();

    ulpb_tx_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32)) dut (
        .CLK_EXT (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int g, input logic [7:0] a, input logic [31:0] d, input logic p);
        bus.REQ_ADDR[g*8 +: 8]  = a;
        bus.REQ_DATA[g*32 +: 32] = d;
        bus.REQ_PEND[g]          = p;
        addr_t[g] = a;
        data_t[g] = d;
        pend_t[g] = p;
    endtask

    // One edge after arbitration: first word of requester g must be on the node port.
    task automatic grant_chk(input int g);
        logic [3:0] oh;
        logic       exp_pri;
        oh = 4'(1 << g);
`ifdef ULPB_ARB_FIXED_PRI_EN
        exp_pri = (g == 0);
`else
        exp_pri = 1'b0;
`endif
        step();
        chk("grant", bus.GRANT, oh);
        chk("tx_req", bus.TX_REQ, 1);
        chk("tx_addr", bus.TX_ADDR, addr_t[g]);
        chk("tx_data", bus.TX_DATA, data_t[g]);
        chk("tx_pend", bus.TX_PEND, pend_t[g]);
        chk("priority", bus.PRIORITY, exp_pri);
        chk("req_ack_idle", bus.REQ_ACK, 0);
    endtask

    // Node accepts the word, then requester and node both drop their side.
    task automatic req_phase(input int g);
        logic [3:0] oh;
        oh = 4'(1 << g);
        bus.TX_ACK = 1'b1;
        step();
        chk("req_ack", bus.REQ_ACK, oh);
        chk("tx_req_after_ack", bus.TX_REQ, 0);
        bus.REQ_VALID[g] = 1'b0;
        bus.TX_ACK = 1'b0;
        step();
        chk("req_ack_drop", bus.REQ_ACK, 0);
        chk("grant_locked", bus.GRANT, oh);
    endtask

    // code 0 = success, 1 = failure, 2 = both flags (failure must win).
    task automatic result_phase(input int g, input int code, input bit keep);
        logic [3:0] oh;
        oh = 4'(1 << g);
        bus.TX_SUCC = (code != 1);
        bus.TX_FAIL = (code != 0);
        step();
        chk("req_succ", bus.REQ_SUCC, (code == 0) ? oh : 4'd0);
        chk("req_fail", bus.REQ_FAIL, (code != 0) ? oh : 4'd0);
        chk("tx_req_result", bus.TX_REQ, 0);
        bus.REQ_RESP_ACK[g] = 1'b1;
        step();
        chk("tx_resp_ack", bus.TX_RESP_ACK, 1);
        chk("grant_rack", bus.GRANT, oh);
        bus.TX_SUCC = 1'b0;
        bus.TX_FAIL = 1'b0;
        bus.REQ_RESP_ACK[g] = 1'b0;
        if (keep) bus.REQ_VALID[g] = 1'b1;
        step();
        chk("grant_release", bus.GRANT, 0);
        chk("tx_resp_ack_clr", bus.TX_RESP_ACK, 0);
        chk("req_succ_clr", bus.REQ_SUCC, 0);
        chk("req_fail_clr", bus.REQ_FAIL, 0);
        $display("txn: requester=%0d result_code=%0d", g, code);
    endtask

    initial begin
        int exp_g;
        rst = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_ADDR = '0;
        bus.REQ_DATA = '0;
        bus.REQ_PEND = '0;
        bus.REQ_RESP_ACK = '0;
        bus.TX_ACK = 1'b0;
        bus.TX_SUCC = 1'b0;
        bus.TX_FAIL = 1'b0;
        for (int i = 0; i < 4; i++) set_word(i, 8'h60 + 8'(i), 32'h1000_0000 + i, 1'b0);
        step();
        step();
        chk("rst_grant", bus.GRANT, 0);
        chk("rst_tx_req", bus.TX_REQ, 0);
        chk("rst_tx_resp_ack", bus.TX_RESP_ACK, 0);
        chk("rst_priority", bus.PRIORITY, 0);
        rst = 1'b0;
        step();
        chk("idle_grant", bus.GRANT, 0);

        // Single word from requester 1, success.
        set_word(1, 8'h55, 32'hDEAD_BEEF, 1'b0);
        bus.REQ_VALID = 4'b0010;
        grant_chk(1);
        req_phase(1);
        result_phase(1, 0, 1'b0);

        // Three-word burst from requester 2; requester 0 arrives and must wait. Pointer is 2.
        set_word(2, 8'h44, 32'hD000_0000, 1'b1);
        bus.REQ_VALID = 4'b0100;
        grant_chk(2);
        bus.REQ_VALID[0] = 1'b1;
        req_phase(2);
        chk("next_tx_req", bus.TX_REQ, 0);
        for (int w = 1; w < 3; w++) begin
            set_word(2, 8'h44, 32'hD000_0000 + w, (w == 1));
            bus.REQ_VALID[2] = 1'b1;
            step();
            chk("burst_grant", bus.GRANT, 4'b0100);
            chk("burst_tx_req", bus.TX_REQ, 1);
            chk("burst_tx_data", bus.TX_DATA, 32'hD000_0000 + w);
            chk("burst_tx_pend", bus.TX_PEND, (w == 1));
            req_phase(2);
        end
        result_phase(2, 0, 1'b0);
        grant_chk(0);
        req_phase(0);
        result_phase(0, 0, 1'b0);

        // Node failure after word 1 of a 2-word burst; second word never goes out. Pointer is 1.
        set_word(2, 8'h44, 32'hE000_0000, 1'b1);
        bus.REQ_VALID = 4'b0100;
        grant_chk(2);
        req_phase(2);
        result_phase(2, 1, 1'b0);
        step();
        chk("abort_no_word2", bus.TX_REQ, 0);
        chk("abort_idle", bus.GRANT, 0);

        // Reset while in WACK with pointer at 3.
        set_word(2, 8'h44, 32'hD000_0000, 1'b0);
        bus.REQ_VALID = 4'b0010;
        grant_chk(1);
        bus.TX_ACK = 1'b1;
        step();
        chk("wack_req_ack", bus.REQ_ACK, 4'b0010);
        rst = 1'b1;
        step();
        chk("mid_rst_grant", bus.GRANT, 0);
        chk("mid_rst_tx_req", bus.TX_REQ, 0);
        chk("mid_rst_req_ack", bus.REQ_ACK, 0);
        chk("mid_rst_tx_addr", bus.TX_ADDR, 0);
        chk("mid_rst_tx_data", bus.TX_DATA, 0);
        rst = 1'b0;
        bus.TX_ACK = 1'b0;
        bus.REQ_VALID = 4'b0000;
        step();

        // All four valid continuously: pointer restarts at 0 after reset.
        bus.REQ_VALID = 4'b1111;
        for (int i = 0; i < 8; i++) begin
`ifdef ULPB_ARB_FIXED_PRI_EN
            exp_g = 0;
`else
            exp_g = i % 4;
`endif
            grant_chk(exp_g);
            req_phase(exp_g);
            result_phase(exp_g, i % 3, 1'b1);
        end
        bus.REQ_VALID = 4'b0000;
        step();

        // Bring pointer to 1, then requesters 0 and 1 compete.
        bus.REQ_VALID = 4'b0001;
        grant_chk(0);
        req_phase(0);
        result_phase(0, 0, 1'b0);
        bus.REQ_VALID = 4'b0011;
`ifdef ULPB_ARB_FIXED_PRI_EN
        exp_g = 0;
`else
        exp_g = 1;
`endif
        grant_chk(exp_g);
        req_phase(exp_g);
        bus.REQ_VALID = 4'b0000;
        result_phase(exp_g, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
